fp_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one single-precision multiplier (start/done handshake, 32-bit op1/op2/res) among N requesters. It accepts one operation at a time and drives the multiplier with a one-cycle start pulse and stable operands. It waits for done, guarded by a watchdog, and returns the result with the requester ID over a back-pressured response channel. It sits between the FPU client ports and the single multiplier instance.

---
 rtl/fp_mul_pkg.sv | 14 +
 rtl/fp_mul_arbiter_rr_arbiter.sv | 32 +++
 rtl/fp_mul_arbiter.sv | 121 ++++++++++++
 tb/tb_fp_mul_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the single-precision multiplier sharing logic.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam int unsigned TIMEOUT_DEFAULT = 32;

endpackage

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first requester after the previous winner, with wrap.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  input  logic           en,
  output logic [N-1:0]   grant_onehot,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    idx          = '0;
    // Positions last+1 .. last+N cover every requester once; last itself is checked last.
    for (int unsigned i = 1; i <= N; i++) begin
      idx = IDW'((32'(last) + i) % N);
      if (en && !any && req[idx]) begin
        grant_onehot[idx] = 1'b1;
        grant_idx         = idx;
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one start/done single-precision multiplier among N requesters, one
// operation at a time, with a watchdog on the done pulse.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned IDW     = $clog2(N),
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [32*N-1:0]   req_op1,
  input  logic [32*N-1:0]   req_op2,
  output logic [N-1:0]      req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [31:0]       resp_res,
  output logic              resp_timeout,
  output logic              mul_start,
  output logic [31:0]       mul_op1,
  output logic [31:0]       mul_op2,
  input  logic [31:0]       mul_res,
  input  logic              mul_done,
  output logic              busy,
  output logic              mul_fault
);

  localparam int unsigned    WDW     = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] grant_idx;
  logic [N-1:0]   grant_onehot;
  logic           grant_any;
  logic [WDW-1:0] wd;
  logic [31:0]    sel_op1;
  logic [31:0]    sel_op2;

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_rr (
    .req          (req_valid),
    .last         (last_grant),
    .en           (state == IDLE),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  assign req_ready  = grant_onehot;
  assign mul_start  = (state == ISSUE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign resp_id    = cur_id;

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_onehot[i]) begin
        sel_op1 = req_op1[32*i +: 32];
        sel_op2 = req_op2[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IDW'(N - 1);
      cur_id       <= '0;
      mul_op1      <= '0;
      mul_op2      <= '0;
      resp_res     <= '0;
      resp_timeout <= 1'b0;
      mul_fault    <= 1'b0;
      wd           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            mul_op1    <= sel_op1;
            mul_op2    <= sel_op2;
            cur_id     <= grant_idx;
            last_grant <= grant_idx;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the expiry cycle still delivers the real product.
          if (mul_done) begin
            resp_res     <= mul_res;
            resp_timeout <= 1'b0;
            state        <= RESP;
          end else if (wd == WD_LAST) begin
            resp_res     <= FP_QNAN;
            resp_timeout <= 1'b1;
            mul_fault    <= 1'b1;
            state        <= RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a behavioural multiplier of programmable latency.
module tb_fp_mul_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_op1;
  logic [32*N-1:0]   req_op2;
  logic [N-1:0]      req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [31:0]       resp_res;
  logic              resp_timeout;
  logic              mul_start;
  logic [31:0]       mul_op1;
  logic [31:0]       mul_op2;
  logic [31:0]       mul_res;
  logic              mul_done;
  logic              busy;
  logic              mul_fault;

  logic model_done;
  logic inj_done;
  logic armed;
  int   lat_cnt;
  int   model_lat;
  int   start_count;
  int   tests;
  int   failed;

  assign mul_done = model_done | inj_done;

  fp_mul_arbiter #(
    .N       (4),
    .IDW     (2),
    .TIMEOUT (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_res     (resp_res),
    .resp_timeout (resp_timeout),
    .mul_start    (mul_start),
    .mul_op1      (mul_op1),
    .mul_op2      (mul_op2),
    .mul_res      (mul_res),
    .mul_done     (mul_done),
    .busy         (busy),
    .mul_fault    (mul_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed IEEE-754 single products for the operand pairs used below.
  function automatic logic [31:0] fmul_lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000;
      {32'h3FC0_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'hC000_0000, 32'h4080_0000}: return 32'hC100_0000;
      {32'h3F00_0000, 32'h3F00_0000}: return 32'h3E80_0000;
      {32'h3F80_0000, 32'h40A0_0000}: return 32'h40A0_0000;
      {32'h4040_0000, 32'h4040_0000}: return 32'h4110_0000;
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Multiplier model: done pulse model_lat cycles after start; model_lat 0 means never.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_done <= 1'b0;
      armed      <= 1'b0;
      lat_cnt    <= 0;
      mul_res    <= '0;
    end else begin
      model_done <= 1'b0;
      if (mul_start) begin
        armed   <= (model_lat > 0);
        lat_cnt <= 1;
      end else if (armed) begin
        lat_cnt <= lat_cnt + 1;
        if (lat_cnt == model_lat) begin
          model_done <= 1'b1;
          mul_res    <= fmul_lut(mul_op1, mul_op2);
          armed      <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (mul_start === 1'b1) start_count <= start_count + 1;
  end

  initial begin
    #100000;
    $display("FAIL tb_time_limit: observed no finish expected finish before 100000");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
    req_op1[32*id +: 32] = a;
    req_op2[32*id +: 32] = b;
    req_valid[id]        = 1'b1;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (resp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resp_wait_bound", 32'(resp_valid), 32'd1);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
  endtask

  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int n;
    int s0;
    s0 = start_count;
    set_req(id, a, b);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid[id] = 1'b0;
    check({tag, "_start"}, 32'(mul_start), 32'd1);
    check({tag, "_op1"}, mul_op1, a);
    check({tag, "_op2"}, mul_op2, b);
    wait_resp(n);
    check({tag, "_id"}, 32'(resp_id), 32'(id));
    check({tag, "_res"}, resp_res, exp);
    check({tag, "_tmo"}, 32'(resp_timeout), 32'd0);
    handshake();
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_starts"}, 32'(start_count - s0), 32'd1);
  endtask

  initial begin
    logic [31:0] rr_a [4];
    logic [31:0] rr_b [4];
    logic [31:0] rr_e [4];
    int n;
    int s0;
    int g;

    tests = 0; failed = 0; start_count = 0; model_lat = 3;
    rst = 1'b1; req_valid = '0; req_op1 = '0; req_op2 = '0;
    resp_ready = 1'b0; inj_done = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_res", resp_res, 32'd0);
    check("rst_resp_tmo", 32'(resp_timeout), 32'd0);
    check("rst_start", 32'(mul_start), 32'd0);
    check("rst_op1", mul_op1, 32'd0);
    check("rst_op2", mul_op2, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(mul_fault), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request from requester 2: 2.0 * 3.0 = 6.0
    run_op(2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "single");

    // All four valid right after reset: grants 0,1,2,3 then 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_a[0] = 32'h4000_0000; rr_b[0] = 32'h4040_0000; rr_e[0] = 32'h40C0_0000;
    rr_a[1] = 32'h3FC0_0000; rr_b[1] = 32'h4000_0000; rr_e[1] = 32'h4040_0000;
    rr_a[2] = 32'hC000_0000; rr_b[2] = 32'h4080_0000; rr_e[2] = 32'hC100_0000;
    rr_a[3] = 32'h3F00_0000; rr_b[3] = 32'h3F00_0000; rr_e[3] = 32'h3E80_0000;
    for (int i = 0; i < 4; i++) set_req(i, rr_a[i], rr_b[i]);
    s0 = start_count;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << g));
      @(negedge clk);
      check("rr_ready_pulse", 32'(req_ready), 32'd0);
      check("rr_start", 32'(mul_start), 32'd1);
      check("rr_op1", mul_op1, rr_a[g]);
      wait_resp(n);
      check("rr_id", 32'(resp_id), 32'(g));
      check("rr_res", resp_res, rr_e[g]);
      handshake();
    end
    req_valid = '0;
    check("rr_starts", 32'(start_count - s0), 32'd5);

    // Back-pressure on requester 1 while requester 3 waits
    set_req(1, 32'h3F80_0000, 32'h40A0_0000);
    #1;
    check("bp_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_req(3, 32'h4040_0000, 32'h4040_0000);
    #1;
    check("bp_no_grant_issue", 32'(req_ready), 32'd0);
    wait_resp(n);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_res", resp_res, 32'h40A0_0000);
      check("bp_id", 32'(resp_id), 32'd1);
      check("bp_no_grant", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    handshake();
    check("bp_next_ready", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    check("bp_next_op1", mul_op1, 32'h4040_0000);
    wait_resp(n);
    check("bp_next_id", 32'(resp_id), 32'd3);
    check("bp_next_res", resp_res, 32'h4110_0000);
    handshake();

    // Multiplier never answers: watchdog response after TIMEOUT cycles in WAIT
    model_lat = 0;
    set_req(0, 32'h4000_0000, 32'h4040_0000);
    #1;
    check("to_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("to_start", 32'(mul_start), 32'd1);
    wait_resp(n);
    check("to_latency", 32'(n), 32'd33);
    check("to_res", resp_res, 32'h7FC0_0000);
    check("to_flag", 32'(resp_timeout), 32'd1);
    check("to_id", 32'(resp_id), 32'd0);
    check("to_fault", 32'(mul_fault), 32'd1);
    handshake();
    model_lat = 3;
    run_op(1, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, "after_to");
    check("to_fault_sticky", 32'(mul_fault), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("to_fault_cleared", 32'(mul_fault), 32'd0);

    // Spurious done in IDLE is ignored
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("spur_valid2", 32'(resp_valid), 32'd0);

    // Done on the watchdog expiry cycle: real result wins
    model_lat = 31;
    set_req(1, 32'h3F00_0000, 32'h3F00_0000);
    #1;
    check("tie_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_resp(n);
    check("tie_latency", 32'(n), 32'd33);
    check("tie_res", resp_res, 32'h3E80_0000);
    check("tie_flag", 32'(resp_timeout), 32'd0);
    check("tie_fault", 32'(mul_fault), 32'd0);
    handshake();

    // Reset during WAIT discards the operation
    model_lat = 20;
    set_req(3, 32'hC000_0000, 32'h4080_0000);
    #1;
    check("mid_ready", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_resp_id", 32'(resp_id), 32'd0);
    check("mid_resp_res", resp_res, 32'd0);
    check("mid_resp_tmo", 32'(resp_timeout), 32'd0);
    check("mid_start", 32'(mul_start), 32'd0);
    check("mid_op1", mul_op1, 32'd0);
    check("mid_op2", mul_op2, 32'd0);
    check("mid_busy_rst", 32'(busy), 32'd0);
    check("mid_fault", 32'(mul_fault), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_lat = 3;
    run_op(2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
